// File: rtl/cam_prio_pkg.sv
// Shared types and helpers for the priority-encoded CAM.
// Holds the write FSM states, the depth helper and the priority encoder function.
package cam_prio_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wr_state_t;

  localparam int unsigned ENC_MAX_DEPTH = 256;
  localparam int unsigned ENC_IDX_W     = 8;

  typedef struct packed {
    logic                 match;
    logic                 multi;
    logic [ENC_IDX_W-1:0] index;
  } prio_res_t;

  function automatic int unsigned cam_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Lowest set bit wins; a second set bit flags a multi-match.
  function automatic prio_res_t prio_encode(input logic [ENC_MAX_DEPTH-1:0] hit);
    prio_res_t r;
    r = '0;
    for (int unsigned i = 0; i < ENC_MAX_DEPTH; i++) begin
      if (hit[i]) begin
        if (r.match) begin
          r.multi = 1'b1;
        end else begin
          r.match = 1'b1;
          r.index = ENC_IDX_W'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_prio_lookup_enc.sv
// Combinational DEPTH-to-index priority encoder with multi-match detect.
// The hit vector is zero-padded to the package encoder's maximum width.
module cam_prio_enc
  import cam_prio_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 5
) (
  input  logic [cam_depth(C_ADDR_WIDTH)-1:0] hit,
  output logic                               match,
  output logic                               multi,
  output logic [C_ADDR_WIDTH-1:0]            index
);

  localparam int unsigned DEPTH = cam_depth(C_ADDR_WIDTH);

  logic [ENC_MAX_DEPTH-1:0] hit_pad;
  prio_res_t                res;
  logic                     unused_idx;

  always_comb begin
    hit_pad             = '0;
    hit_pad[DEPTH-1:0]  = hit;
  end

  assign res        = prio_encode(hit_pad);
  assign match      = res.match;
  assign multi      = res.multi;
  assign index      = res.index[C_ADDR_WIDTH-1:0];
  assign unused_idx = ^res.index;

endmodule

// File: rtl/cam_prio_lookup.sv
// Pipelined binary CAM with per-entry valid bits and a priority-encoded result.
// Define CAM_TERNARY_EN to add DIN_MASK and per-entry don't-care mask storage.
module cam_prio_lookup
  import cam_prio_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH       = 5,
  parameter int unsigned C_DATA_WIDTH       = 32,
  parameter int unsigned C_MATCH_ADDR_WIDTH = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WE,
  input  logic [C_ADDR_WIDTH-1:0]       WR_ADDR,
  input  logic                          WR_VLD,
  input  logic [C_DATA_WIDTH-1:0]       DIN,
`ifdef CAM_TERNARY_EN
  input  logic [C_DATA_WIDTH-1:0]       DIN_MASK,
`endif
  output logic                          BUSY,
  input  logic                          CMP_VALID,
  input  logic [C_DATA_WIDTH-1:0]       CMP_DIN,
  output logic                          MATCH_VALID,
  output logic                          MATCH,
  output logic [C_MATCH_ADDR_WIDTH-1:0] MATCH_ADDR,
  output logic                          MULTI_MATCH
);

  localparam int unsigned DEPTH = cam_depth(C_ADDR_WIDTH);

  wr_state_t state_q, state_d;
  logic      wr_accept;

  logic [C_DATA_WIDTH-1:0] key_mem [DEPTH];
`ifdef CAM_TERNARY_EN
  logic [C_DATA_WIDTH-1:0] mask_mem [DEPTH];
`endif
  logic [DEPTH-1:0]        valid_q;

  logic [DEPTH-1:0]        hit_d;
  logic [DEPTH-1:0]        hit_q;
  logic                    s1_vld_q;

  logic                    enc_match;
  logic                    enc_multi;
  logic [C_ADDR_WIDTH-1:0] enc_index;

  // Write FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    BUSY      = 1'b0;
    case (state_q)
      IDLE: begin
        if (WE) begin
          wr_accept = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        BUSY    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key (and mask) storage is deliberately unreset; only the valid bits gate hits.
  always_ff @(posedge CLK) begin
    if (wr_accept && WR_VLD) begin
      key_mem[WR_ADDR]  <= DIN;
`ifdef CAM_TERNARY_EN
      mask_mem[WR_ADDR] <= DIN_MASK;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (wr_accept) begin
      valid_q[WR_ADDR] <= WR_VLD;
    end
  end

  // S1 compares against the pre-edge contents, so a same-cycle write is not seen.
  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef CAM_TERNARY_EN
      hit_d[i] = valid_q[i] && (((key_mem[i] ^ CMP_DIN) & ~mask_mem[i]) == '0);
`else
      hit_d[i] = valid_q[i] && (key_mem[i] == CMP_DIN);
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= CMP_VALID;
      if (CMP_VALID) begin
        hit_q <= hit_d;
      end
    end
  end

  cam_prio_enc #(
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_enc (
    .hit   (hit_q),
    .match (enc_match),
    .multi (enc_multi),
    .index (enc_index)
  );

  // S2: result registers hold their value between strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MATCH_VALID <= 1'b0;
      MATCH       <= 1'b0;
      MATCH_ADDR  <= '0;
      MULTI_MATCH <= 1'b0;
    end else begin
      MATCH_VALID <= s1_vld_q;
      if (s1_vld_q) begin
        MATCH       <= enc_match;
        MATCH_ADDR  <= C_MATCH_ADDR_WIDTH'(enc_index);
        MULTI_MATCH <= enc_multi;
      end
    end
  end

endmodule
